add_num_job_sequencer: RTL

//  Sequences a multi-line add job on CCI-P: streams NUM read requests from src_base, adds byte1+byte2
//  of each returned line, and writes the 8-bit sum (zero-extended) to dst_base+index.

---
 rtl/add_num_job_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/add_num_job_sequencer.sv
// Streams a block of read requests, adds bytes 1 and 2 of each returned line and writes the
// 8-bit sum to the matching destination line, bounding in-flight work with a credit counter.
module add_num_job_sequencer #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CL_ADDR_W       = 42,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CL_ADDR_W-1:0] src_base,
    input  logic [CL_ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]     num_lines,
    input  logic                 c0TxAlmFull,
    input  logic                 c1TxAlmFull,
    output logic                 rd_req_valid,
    output logic [CL_ADDR_W-1:0] rd_req_addr,
    output logic [CNT_W-1:0]     rd_req_mdata,
    input  logic                 rd_rsp_valid,
    input  logic [CNT_W-1:0]     rd_rsp_mdata,
    input  logic [511:0]         rd_rsp_data,
    output logic                 wr_req_valid,
    output logic [CL_ADDR_W-1:0] wr_req_addr,
    output logic [511:0]         wr_req_data,
    input  logic                 wr_rsp_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [CL_ADDR_W-1:0] src_base_q, dst_base_q;
    logic [CNT_W-1:0]     num_q, rd_issued, wr_acks, acks_next;
    logic [OCC_W-1:0]     inflight, fifo_count;
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [7:0]           wr_sum_q;

    logic [CL_ADDR_W-1:0] fifo_addr [MAX_OUTSTANDING];
    logic [7:0]           fifo_sum  [MAX_OUTSTANDING];

    logic                 in_run, rsp_push, ack, fifo_empty, fifo_full;
    logic                 rd_issue, wr_pop, accept_start;
    logic [CL_ADDR_W-1:0] push_addr, head_addr;
    logic [7:0]           push_sum, head_sum;

    assign in_run     = (state == ST_RUN);
    assign rsp_push   = in_run && rd_rsp_valid;
    assign ack        = in_run && wr_rsp_valid;
    assign acks_next  = wr_acks + CNT_W'(ack);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == OCC_W'(MAX_OUTSTANDING));

    assign push_addr  = dst_base_q + CL_ADDR_W'(rd_rsp_mdata);
    assign push_sum   = rd_rsp_data[15:8] + rd_rsp_data[23:16];

    // An empty FIFO forwards the arriving response so a write can go out the very next cycle.
    assign head_addr  = fifo_empty ? push_addr : fifo_addr[rd_ptr];
    assign head_sum   = fifo_empty ? push_sum  : fifo_sum[rd_ptr];

    assign wr_pop     = in_run && (!fifo_empty || rsp_push) && !c1TxAlmFull;
    assign rd_issue   = in_run && (rd_issued < num_q) && !c0TxAlmFull
                        && (inflight < OCC_W'(MAX_OUTSTANDING));

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign wr_req_data = {504'b0, wr_sum_q};

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = (num_lines == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (acks_next == num_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Credits cover reads awaiting a response plus buffered writes; a response just moves a credit
    // from the first group to the second, so only issue and pop change the total.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            src_base_q   <= '0;
            dst_base_q   <= '0;
            num_q        <= '0;
            rd_issued    <= '0;
            wr_acks      <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_sum_q     <= '0;
        end else begin
            state        <= state_next;
            rd_req_valid <= rd_issue;
            wr_req_valid <= wr_pop;
            if (rd_issue) begin
                rd_req_addr  <= src_base_q + CL_ADDR_W'(rd_issued);
                rd_req_mdata <= rd_issued;
                rd_issued    <= rd_issued + CNT_W'(1);
            end
            if (wr_pop) begin
                wr_req_addr <= head_addr;
                wr_sum_q    <= head_sum;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            if (rsp_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ack) begin
                wr_acks <= acks_next;
            end
            inflight   <= inflight + OCC_W'(rd_issue) - OCC_W'(wr_pop);
            fifo_count <= fifo_count + OCC_W'(rsp_push) - OCC_W'(wr_pop);
            if (accept_start) begin
                src_base_q <= src_base;
                dst_base_q <= dst_base;
                num_q      <= num_lines;
                rd_issued  <= '0;
                wr_acks    <= '0;
                inflight   <= '0;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_sum[wr_ptr]  <= push_sum;
        end
    end

    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_push && fifo_full && !wr_pop));

endmodule
